// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with a word-aligned memory port
//
// Purpose: accepts one load/store request at a time from the core, checks
// width/alignment, drives a word-addressed memory request with byte lanes,
// waits (bounded) for load data, extracts and extends it, and returns a
// response with an error flag.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      core request handshake (ready only in IDLE)
//   i_is_store, i_funct3, i_addr,  request: direction, RV32I width code,
//   i_wdata                        byte address, store data
//   o_rsp_valid / i_rsp_ready      completion handshake toward the core
//   o_rsp_data, o_rsp_err          extended load result / error flag
//   o_mem_req_valid /              memory request handshake
//   i_mem_req_ready
//   o_mem_addr, o_mem_we,          word address, write enable, byte lanes,
//   o_mem_wmask, o_mem_wdata       lane-replicated store data
//   i_mem_rsp_valid, i_mem_rdata   read return pulse and data
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  // One extra bit so TIMEOUT_CYCLES = 65535 compares without wrapping.
  localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_addr;
  logic        r_mem_we;
  logic [3:0]  r_mem_wmask;
  logic [31:0] r_mem_wdata;

  logic        w_req_err;
  logic [3:0]  w_st_mask;
  logic [31:0] w_st_data;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_data;
  logic        w_timeout;

  // Request legality: unsupported width codes, unsigned stores, misalignment.
  always_comb begin
    w_req_err = 1'b0;
    case (i_funct3)
      3'b000:  w_req_err = 1'b0;
      3'b001:  w_req_err = i_addr[0];
      3'b010:  w_req_err = |i_addr[1:0];
      3'b100:  w_req_err = i_is_store;
      3'b101:  w_req_err = i_is_store | i_addr[0];
      default: w_req_err = 1'b1;
    endcase
  end

  // Store lane placement: data is replicated across the word so the mask
  // alone selects which bytes memory writes.
  always_comb begin
    w_st_mask = 4'b1111;
    w_st_data = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_st_mask = 4'b0001 << i_addr[1:0];
        w_st_data = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_st_mask = i_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{i_wdata[15:0]}};
      end
      default: begin
        w_st_mask = 4'b1111;
        w_st_data = i_wdata;
      end
    endcase
  end

  // Load extraction uses the registered request, not the live core inputs.
  always_comb begin
    w_ld_byte = i_mem_rdata[7:0];
    case (r_addr_lo)
      2'd0: w_ld_byte = i_mem_rdata[7:0];
      2'd1: w_ld_byte = i_mem_rdata[15:8];
      2'd2: w_ld_byte = i_mem_rdata[23:16];
      2'd3: w_ld_byte = i_mem_rdata[31:24];
      default: w_ld_byte = i_mem_rdata[7:0];
    endcase
  end

  assign w_ld_half = r_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_ld_data = i_mem_rdata;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = i_mem_rdata;
    endcase
  end

  // True in the WAIT cycle that completes TIMEOUT_CYCLES cycles of waiting.
  assign w_timeout = (({1'b0, r_cnt} + 17'd1) == LP_TIMEOUT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_is_store      <= 1'b0;
      r_funct3        <= 3'd0;
      r_addr_lo       <= 2'd0;
      r_cnt           <= 16'd0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= 32'd0;
      r_rsp_err       <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_mem_we        <= 1'b0;
      r_mem_wmask     <= 4'd0;
      r_mem_wdata     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_is_store <= i_is_store;
            r_funct3   <= i_funct3;
            r_addr_lo  <= i_addr[1:0];
            if (w_req_err) begin
              // Illegal request: respond at once without touching memory.
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= 32'd0;
              r_state     <= S_RESP;
            end else begin
              r_mem_req_valid <= 1'b1;
              r_mem_addr      <= {i_addr[31:2], 2'b00};
              r_mem_we        <= i_is_store;
              r_mem_wmask     <= i_is_store ? w_st_mask : 4'd0;
              r_mem_wdata     <= i_is_store ? w_st_data : 32'd0;
              r_state         <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= 32'd0;
            r_mem_we        <= 1'b0;
            r_mem_wmask     <= 4'd0;
            r_mem_wdata     <= 32'd0;
            if (r_is_store) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_data  <= 32'd0;
              r_state     <= S_RESP;
            end else begin
              r_cnt   <= 16'd0;
              r_state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          // Data arriving in the final cycle still beats the timeout.
          if (i_mem_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= w_ld_data;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= 32'd0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so ready drops immediately on assertion and rises in the
  // first cycle after release.
  assign o_req_ready     = (r_state == S_IDLE) & i_rst_n;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_rsp_err       = r_rsp_err;
  assign o_mem_req_valid = r_mem_req_valid;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_we        = r_mem_we;
  assign o_mem_wmask     = r_mem_wmask;
  assign o_mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wmask(mem_wmask),
    .o_mem_wdata(mem_wdata),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata)
  );

  typedef struct {
    bit        st;
    bit [2:0]  f3;
    bit [31:0] a, wd, rd;
    int        lat, mrdy, rrdy;
    bit        err;
    bit [31:0] data;
    bit        seen;
    bit [31:0] maddr;
    bit        we;
    bit [3:0]  mask;
    bit [31:0] mwd;
    int        waitc, edges;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Reference: derived directly from the RV32I width/alignment rules.
  function automatic vec_t model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                 input bit [31:0] wd, input bit [31:0] rd,
                                 input int lat, input int mrdy, input int rrdy);
    vec_t v;
    int size, off;
    longint val, half_range;
    v = '{st: st, f3: f3, a: a, wd: wd, rd: rd, lat: lat, mrdy: mrdy, rrdy: rrdy,
          err: 0, data: 0, seen: 0, maddr: 0, we: 0, mask: 0, mwd: 0, waitc: 0, edges: 0};
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (st && f3 >= 3'd4) || (a % size != 0)) begin
      v.err   = 1;
      v.edges = 2 + rrdy;
      return v;
    end
    v.seen  = 1;
    v.maddr = a - off;
    if (st) begin
      v.we    = 1;
      v.mask  = 4'(((1 << size) - 1) << off);
      v.mwd   = (size == 1) ? wd[7:0] * 32'h01010101 :
                (size == 2) ? wd[15:0] * 32'h00010001 : wd;
      v.edges = 3 + mrdy + rrdy;
      return v;
    end
    if (lat < 1 || lat > TMO) begin
      v.err   = 1;
      v.waitc = TMO;
    end else begin
      v.waitc = lat;
      val = longint'(rd >> (8 * off));
      if (size < 4) begin
        half_range = longint'(1) << (8 * size - 1);
        val = val % (2 * half_range);
        if (!f3[2] && val >= half_range) val = val - 2 * half_range;
      end
      v.data = 32'(val);
    end
    v.edges = 3 + mrdy + v.waitc + rrdy;
    return v;
  endfunction

  task automatic run_txn(input vec_t e, output vec_t g);
    int k;
    g = e;
    g.err = 0; g.data = 0; g.seen = 0; g.maddr = 0; g.we = 0; g.mask = 0; g.mwd = 0;
    g.waitc = 0; g.edges = 0;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; is_store = e.st; funct3 = e.f3; addr = e.a; wdata = e.wd;
    @(posedge clk); #1; g.edges++;
    req_valid = 0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    chk("req_ready_busy", req_ready, 0);
    if (mem_req_valid) begin
      g.seen = 1; g.maddr = mem_addr; g.we = mem_we; g.mask = mem_wmask; g.mwd = mem_wdata;
      for (int i = 0; i < e.mrdy; i++) begin
        @(posedge clk); #1; g.edges++;
        chk("hold_mem_req_valid", mem_req_valid, 1);
        chk("hold_mem_addr", mem_addr, g.maddr);
        chk("hold_mem_we", mem_we, g.we);
        chk("hold_mem_wmask", mem_wmask, g.mask);
        chk("hold_mem_wdata", mem_wdata, g.mwd);
      end
      mem_req_ready = 1;
      @(posedge clk); #1; g.edges++;
      mem_req_ready = 0;
      chk("mem_req_drop", mem_req_valid, 0);
    end
    k = 0;
    while (!rsp_valid && k < 40) begin
      k++;
      if (k == e.lat) begin mem_rsp_valid = 1; mem_rdata = e.rd; end
      @(posedge clk); #1; g.edges++;
      mem_rsp_valid = 0; mem_rdata = $urandom;
    end
    g.waitc = k;
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait: rsp_valid=0 after %0d cycles, required 1", k);
    end
    g.err = rsp_err; g.data = rsp_data;
    for (int i = 0; i < e.rrdy; i++) begin
      req_valid = 1; is_store = 1; funct3 = 3'd0;
      @(posedge clk); #1; g.edges++;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, g.data);
      chk("hold_rsp_err", rsp_err, g.err);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1; g.edges++;
    rsp_ready = 0;
    chk("rsp_drop", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
  endtask

  task automatic compare(input string tag, input vec_t e, input vec_t g);
    chk({tag, "_err"}, g.err, e.err);
    chk({tag, "_data"}, g.data, e.data);
    chk({tag, "_mem_seen"}, g.seen, e.seen);
    chk({tag, "_waitc"}, g.waitc, e.waitc);
    chk({tag, "_edges"}, g.edges, e.edges);
    if (e.seen) begin
      chk({tag, "_mem_addr"}, g.maddr, e.maddr);
      chk({tag, "_mem_we"}, g.we, e.we);
      chk({tag, "_mem_wmask"}, g.mask, e.mask);
      chk({tag, "_mem_wdata"}, g.mwd, e.mwd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    vec_t e, g;
    bit st;
    bit [2:0] f3;
    bit [31:0] a;

    // st f3 a wd rd lat mrdy rrdy | err data seen maddr we mask mwd waitc edges
    vt[0]  = '{1, 3'd0, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 0, 0, 0, 32'h0, 1, 32'h1000, 1, 4'b1000, 32'hDDDDDDDD, 0, 3};
    vt[1]  = '{0, 3'd0, 32'h2001, 32'h0, 32'h12348056, 2, 0, 0, 0, 32'hFFFFFF80, 1, 32'h2000, 0, 4'b0000, 32'h0, 2, 5};
    vt[2]  = '{0, 3'd4, 32'h2001, 32'h0, 32'h12348056, 2, 0, 0, 0, 32'h00000080, 1, 32'h2000, 0, 4'b0000, 32'h0, 2, 5};
    vt[3]  = '{0, 3'd1, 32'h2002, 32'h0, 32'h12348056, 2, 0, 0, 0, 32'h00001234, 1, 32'h2000, 0, 4'b0000, 32'h0, 2, 5};
    vt[4]  = '{0, 3'd2, 32'h3002, 32'h0, 32'h0, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 2};
    vt[5]  = '{0, 3'd3, 32'h3000, 32'h0, 32'h0, 1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 2};
    vt[6]  = '{0, 3'd2, 32'h4000, 32'h0, 32'h5555AAAA, 0, 0, 0, 1, 32'h0, 1, 32'h4000, 0, 4'b0000, 32'h0, 4, 7};
    vt[7]  = '{1, 3'd1, 32'h0012, 32'h1234ABCD, 32'h0, 0, 5, 3, 0, 32'h0, 1, 32'h0010, 1, 4'b1100, 32'hABCDABCD, 0, 11};
    vt[8]  = '{0, 3'd5, 32'h0022, 32'h0, 32'h80017FFF, 4, 0, 0, 0, 32'h00008001, 1, 32'h0020, 0, 4'b0000, 32'h0, 4, 7};
    vt[9]  = '{0, 3'd2, 32'h0030, 32'h0, 32'h11111111, 5, 0, 0, 1, 32'h0, 1, 32'h0030, 0, 4'b0000, 32'h0, 4, 7};
    vt[10] = '{1, 3'd4, 32'h0040, 32'h55, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 2};
    vt[11] = '{1, 3'd1, 32'h0005, 32'h55, 32'h0, 0, 0, 0, 1, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 0, 2};
    vt[12] = '{0, 3'd1, 32'h0006, 32'h0, 32'h80000000, 1, 0, 0, 0, 32'hFFFF8000, 1, 32'h0004, 0, 4'b0000, 32'h0, 1, 4};
    vt[13] = '{1, 3'd2, 32'h0008, 32'hCAFEF00D, 32'h0, 0, 1, 0, 0, 32'h0, 1, 32'h0008, 1, 4'b1111, 32'hCAFEF00D, 0, 4};
    vt[14] = '{0, 3'd0, 32'h0003, 32'h0, 32'h7F000000, 3, 0, 1, 0, 32'h0000007F, 1, 32'h0000, 0, 4'b0000, 32'h0, 3, 7};

    rst_n = 0; req_valid = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    rsp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;

    @(posedge clk); @(posedge clk); #3;
    chk_all_zero("reset");
    rst_n = 1; #1;
    chk("release_req_ready", req_ready, 1);
    @(posedge clk); #1;

    foreach (vt[i]) begin
      run_txn(vt[i], g);
      compare($sformatf("vec%0d", i), vt[i], g);
    end

    // Data arriving in IDLE after a timed-out load must be ignored.
    mem_rsp_valid = 1; mem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk("stale_idle_rsp_valid", rsp_valid, 0);
    chk("stale_idle_req_ready", req_ready, 1);

    // Reset asserted mid-ISSUE clears the memory request immediately.
    req_valid = 1; is_store = 1; funct3 = 3'd2; addr = 32'h80; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 0;
    chk("issue_mem_req_valid", mem_req_valid, 1);
    #2 rst_n = 0; #1;
    chk_all_zero("rst_issue");
    #1 rst_n = 1; #1;
    chk("rst_issue_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Reset asserted mid-WAIT; a late memory response must not complete it.
    req_valid = 1; is_store = 0; funct3 = 3'd2; addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 0; mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    @(posedge clk); #1;
    chk("wait_rsp_valid", rsp_valid, 0);
    #2 rst_n = 0; #1;
    chk_all_zero("rst_wait");
    #1 rst_n = 1; #1;
    chk("rst_wait_req_ready", req_ready, 1);
    @(posedge clk); #1;
    mem_rsp_valid = 1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk("late_rsp_valid", rsp_valid, 0);
    chk("late_req_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("late_rsp_valid2", rsp_valid, 0);

    // Randomised transactions against the reference model.
    for (int n = 0; n < 60; n++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        else if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      e = model(st, f3, a, $urandom, $urandom, $urandom_range(0, 6),
                $urandom_range(0, 2), $urandom_range(0, 2));
      run_txn(e, g);
      compare($sformatf("rnd%0d", n), e, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning: max cycles in WAIT before a load is aborted with error (legal range 1..65535).
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserted low clears all state immediately.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request (high only in IDLE).
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 addr  input  32  byte address (base + immediate, already added).
REQ-009 wdata  input  32  store data (rs2).
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  completion handshake toward core.
REQ-011 rsp_data  output  32  extended load result; 0 for stores and errors.
REQ-012 rsp_err  output  1  misaligned, illegal funct3, or timeout.
REQ-013 mem_req_valid / mem_req_ready  output / input  1 / 1  memory request handshake.
REQ-014 mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-015 mem_we  output  1  write enable; mem_wmask output 4 byte lanes; mem_wdata output 32 lane-replicated data.
REQ-016 mem_rsp_valid / mem_rdata  input / input  1 / 32  read return, one-cycle pulse, no backpressure.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding free.
REQ-018 IDLE: req_ready=1; on req_valid register is_store, funct3, addr, wdata; next ISSUE, or RESP with rsp_err=1 if checks of REQ-019 fail (no memory access).
REQ-019 Error checks: funct3 in {011,110,111}, store with funct3 in {100,101}, halfword with addr[0]=1, word with addr[1:0]!=0.
REQ-020 ISSUE: mem_req_valid=1, all mem_* fields stable from registered values until mem_req_ready sampled high; store -> RESP, load -> WAIT.
REQ-021 Store lanes: sb mem_wdata={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0]; sh mem_wdata={2{wdata[15:0]}}, mask 0011 (addr[1]=0) or 1100; sw mask 1111; loads mask 0000, mem_we=0.
REQ-022 WAIT: on mem_rsp_valid capture extracted data into rsp_data, rsp_err=0, -> RESP.
REQ-023 Load extract: b/bu select byte addr[1:0], h/hu select half addr[1]; b/h sign-extend from bit 7/15; bu/hu zero-extend; w pass through.
REQ-024 Timeout counter SHALL clear on WAIT entry, increment each WAIT cycle; when count reaches TIMEOUT_CYCLES with no mem_rsp_valid -> RESP, rsp_err=1, rsp_data=0; mem_rsp_valid on that same cycle wins (no error).
REQ-025 RESP: rsp_valid=1, rsp_data/rsp_err held until rsp_ready sampled high, then IDLE; minimum 1 cycle in RESP.
REQ-026 mem_rsp_valid outside WAIT SHALL be ignored; req_valid outside IDLE SHALL be ignored (not queued).
REQ-027 Latency: store with mem_req_ready=1 and rsp_ready=1 completes in 3 cycles (IDLE->ISSUE->RESP->IDLE); load adds WAIT cycles equal to memory latency.

Reset
REQ-028 While rst=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mem_req_valid=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-029 Reset asserted mid-ISSUE/WAIT SHALL abort the transaction; late mem_rsp_valid after release SHALL be ignored; req_ready=1 first cycle after release.

Verification
REQ-030 sb addr=0x1003 wdata=0xAABBCCDD, mem_req_ready=1 -> mem_addr=0x1000, mem_wdata=0xDDDDDDDD, mask=1000, we=1; rsp_valid, rsp_data=0, err=0.
REQ-031 lb addr=0x2001, mem_rdata=0x12348056 after 2 WAIT cycles -> rsp_data=0xFFFFFF80; same with lbu -> 0x00000080; lh addr=0x2002 -> 0x00001234.
REQ-032 lw addr=0x3002 -> RESP next cycle, rsp_err=1, mem_req_valid never asserted; funct3=011 same result.
REQ-033 TIMEOUT_CYCLES=4, load with no mem_rsp_valid -> rsp_err=1, rsp_data=0 after 4 WAIT cycles; later mem_rsp_valid ignored.
REQ-034 mem_req_ready low 5 cycles -> mem_* fields stable all 5 cycles; rsp_ready low 3 cycles in RESP -> rsp_valid/data held, req_ready=0.
REQ-035 rst low during WAIT -> all outputs 0 immediately (async); after release, stale mem_rsp_valid produces no rsp_valid.
